// File: rtl/dtw_pkg.sv
// Shared encodings for the second-generation DTW core controller:
// command modes, controller states and result-packet constants.
package dtw_pkg;

    typedef enum logic [1:0] {
        OP_QUERY  = 2'd0,
        OP_LOAD   = 2'd1,
        OP_TQUERY = 2'd2,
        OP_RSVD   = 2'd3
    } op_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        REF_LOAD,
        Q_HDR,
        Q_RUN,
        Q_WAIT,
        Q_OUT
    } state_e;

    localparam logic [7:0]  RES_TAG   = 8'hA5;
    localparam int unsigned RES_WORDS = 3;

endpackage

// File: rtl/dtw_ctrl_v2_if.sv
// Source/sink FIFO handshake bundle between the DTW controller and the
// AXI-stream FIFOs (source is first-word-fall-through).
interface dtw_ctrl_v2_if #(
    parameter int unsigned AXI_DW = 32
);
    logic              src_rden;
    logic              src_empty;
    logic [AXI_DW-1:0] src_data;
    logic              sink_wren;
    logic              sink_full;
    logic [AXI_DW-1:0] sink_data;

    modport master (
        output src_rden,
        input  src_empty,
        input  src_data,
        output sink_wren,
        input  sink_full,
        output sink_data
    );

    modport slave (
        input  src_rden,
        output src_empty,
        output src_data,
        input  sink_wren,
        output sink_full,
        input  sink_data
    );
endinterface

// File: rtl/dtw_result_ser.sv
// Result packet serialiser: pushes RES_WORDS words in order, holding the
// current word stable while the sink is full.
module dtw_result_ser
    import dtw_pkg::*;
#(
    parameter int unsigned AXI_DW = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic [RES_WORDS-1:0][AXI_DW-1:0] words,
    input  logic                             full,
    output logic                             wren,
    output logic [AXI_DW-1:0]                data,
    output logic                             last
);

    localparam int unsigned IW = $clog2(RES_WORDS);

    logic          active;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            idx    <= '0;
        end else if (load) begin
            active <= 1'b1;
            idx    <= '0;
        end else if (wren) begin
            if (last) begin
                active <= 1'b0;
                idx    <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    always_comb begin
        wren = active && !full;
        data = active ? words[idx] : '0;
        last = wren && (idx == IW'(RES_WORDS - 1));
    end

endmodule

// File: rtl/dtw_ctrl_v2.sv
// DTW core controller: sequences reference loading, query header capture,
// squiggle streaming to the datapath and result packetisation.
module dtw_ctrl_v2
    import dtw_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned AXI_DW  = 32,
    parameter int unsigned REF_AW  = 15,
    parameter int unsigned SQG_MAX = 250,
    parameter int unsigned SQG_CW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op_mode,
    input  logic [AXI_DW-1:0] ref_len,
    input  logic [SQG_CW-1:0] sqg_len,
    input  logic [DW-1:0]     threshold,
    output logic              busy,
    output logic              done,
    output logic              err,
    dtw_ctrl_v2_if.master     fifo,
    output logic              ref_wren,
    output logic [REF_AW-1:0] ref_waddr,
    output logic [DW-1:0]     ref_wdata,
    output logic [REF_AW-1:0] ref_raddr,
    output logic              dp_rst,
    output logic              dp_en,
    output logic [DW-1:0]     dp_sample,
    input  logic [DW-1:0]     dp_minval,
    input  logic [AXI_DW-1:0] dp_position,
    input  logic              dp_done
);

    localparam logic [AXI_DW:0]   REF_MAX = (AXI_DW + 1)'(1) << REF_AW;
    localparam logic [SQG_CW-1:0] SQG_LIM = SQG_CW'(SQG_MAX);

    state_e            state_q, state_d;
    op_mode_e          op_q;
    logic [AXI_DW-1:0] ref_len_q;
    logic [SQG_CW-1:0] sqg_len_q;
    logic [DW-1:0]     thr_q;
    logic [AXI_DW-1:0] qid_q;
    logic [AXI_DW-1:0] pos_q;
    logic [DW-1:0]     min_q;
    logic [AXI_DW-1:0] ref_cnt;
    logic [SQG_CW-1:0] sqg_cnt;

    logic cmd_bad;
    logic pop;
    logic done_set;
    logic ser_load;
    logic ser_last;
    logic [RES_WORDS-1:0][AXI_DW-1:0] res_words;

    always_comb begin
        cmd_bad = 1'b0;
        if (op_mode == OP_RSVD || ref_len == '0 || {1'b0, ref_len} > REF_MAX)
            cmd_bad = 1'b1;
        if (op_mode != OP_LOAD && (sqg_len == '0 || sqg_len > SQG_LIM))
            cmd_bad = 1'b1;
    end

    always_comb begin
        pop      = !fifo.src_empty && (state_q inside {REF_LOAD, Q_HDR, Q_RUN});
        state_d  = state_q;
        done_set = 1'b0;
        ser_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cmd_bad)
                        done_set = 1'b1;
                    else if (op_mode == OP_LOAD)
                        state_d = REF_LOAD;
                    else
                        state_d = Q_HDR;
                end
            end
            REF_LOAD: begin
                if (pop && ref_cnt == ref_len_q - AXI_DW'(1)) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            Q_HDR: begin
                if (pop)
                    state_d = Q_RUN;
            end
            Q_RUN: begin
                if (pop && sqg_cnt == sqg_len_q - SQG_CW'(1))
                    state_d = Q_WAIT;
            end
            Q_WAIT: begin
                if (dp_done) begin
                    // Live minval equals the value latched on this same edge.
                    if (op_q == OP_TQUERY && dp_minval > thr_q) begin
                        state_d  = IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d  = Q_OUT;
                        ser_load = 1'b1;
                    end
                end
            end
            Q_OUT: begin
                if (ser_last) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            dp_rst    <= 1'b1;
            op_q      <= OP_QUERY;
            ref_len_q <= '0;
            sqg_len_q <= '0;
            thr_q     <= '0;
            qid_q     <= '0;
            pos_q     <= '0;
            min_q     <= '0;
            ref_cnt   <= '0;
            sqg_cnt   <= '0;
        end else begin
            state_q <= state_d;
            done    <= done_set;
            dp_rst  <= !(state_d inside {Q_RUN, Q_WAIT, Q_OUT});
            if (state_q == IDLE && start) begin
                err       <= cmd_bad;
                op_q      <= op_mode_e'(op_mode);
                ref_len_q <= ref_len;
                sqg_len_q <= sqg_len;
                thr_q     <= threshold;
                ref_cnt   <= '0;
                sqg_cnt   <= '0;
            end
            if (state_q == REF_LOAD && pop)
                ref_cnt <= ref_cnt + AXI_DW'(1);
            if (state_q == Q_HDR && pop)
                qid_q <= fifo.src_data;
            if (state_q == Q_RUN && pop)
                sqg_cnt <= sqg_cnt + SQG_CW'(1);
            if (state_q == Q_WAIT && dp_done) begin
                min_q <= dp_minval;
                pos_q <= dp_position;
            end
        end
    end

    always_comb begin
        busy          = (state_q != IDLE);
        fifo.src_rden = pop;
        ref_wren      = pop && (state_q == REF_LOAD);
        ref_waddr     = ref_cnt[REF_AW-1:0];
        ref_wdata     = ref_wren ? fifo.src_data[DW-1:0] : '0;
        ref_raddr     = REF_AW'(sqg_cnt);
        dp_en         = pop && (state_q == Q_RUN);
        dp_sample     = dp_en ? fifo.src_data[DW-1:0] : '0;
    end

    // Tag sits in the top byte; minval is zero-extended below it.
    always_comb begin
        res_words[0] = qid_q;
        res_words[1] = pos_q;
        res_words[2] = (AXI_DW'(RES_TAG) << (AXI_DW - 8)) | AXI_DW'(min_q);
    end

    dtw_result_ser #(
        .AXI_DW(AXI_DW)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .load (ser_load),
        .words(res_words),
        .full (fifo.sink_full),
        .wren (fifo.sink_wren),
        .data (fifo.sink_data),
        .last (ser_last)
    );

endmodule

// File: tb/tb_dtw_ctrl_v2.sv
// Randomised self-checking bench for dtw_ctrl_v2: FIFO/datapath models drive
// commands and a command-level model predicts writes, samples and packets.
module tb_dtw_ctrl_v2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_mode = '0;
    logic [31:0] ref_len = '0;
    logic [7:0]  sqg_len = '0;
    logic [15:0] threshold = '0;
    logic        busy, done, err;
    logic        ref_wren, dp_rst, dp_en;
    logic [14:0] ref_waddr, ref_raddr;
    logic [15:0] ref_wdata, dp_sample;
    logic [15:0] dp_minval = '0;
    logic [31:0] dp_position = '0;
    logic        dp_done = 1'b0;

    dtw_ctrl_v2_if #(.AXI_DW(32)) fifo ();

    dtw_ctrl_v2 #(
        .DW(16), .AXI_DW(32), .REF_AW(15), .SQG_MAX(250), .SQG_CW(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op_mode(op_mode),
        .ref_len(ref_len), .sqg_len(sqg_len), .threshold(threshold),
        .busy(busy), .done(done), .err(err), .fifo(fifo),
        .ref_wren(ref_wren), .ref_waddr(ref_waddr), .ref_wdata(ref_wdata),
        .ref_raddr(ref_raddr), .dp_rst(dp_rst), .dp_en(dp_en),
        .dp_sample(dp_sample), .dp_minval(dp_minval),
        .dp_position(dp_position), .dp_done(dp_done)
    );

    always #5 clk = ~clk;

    logic [32:0] src_q[$];      // bit 32 marks a one-cycle empty bubble
    logic [31:0] data_q[$];
    logic [31:0] sink_got[$];
    logic [15:0] dp_got[$];
    logic [30:0] wr_got[$];
    int          done_cnt = 0;
    int          viol = 0;
    int          stab_err = 0;
    logic        prev_full = 1'b0;
    logic [31:0] prev_data = '0;
    int          fmode = 0;
    logic        hold_arm = 1'b0;
    int          hold_left = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (src_q.size() > 0 && src_q[0][32]) begin
            void'(src_q.pop_front());
            fifo.src_empty = 1'b1;
            fifo.src_data  = $urandom();
        end else if (src_q.size() > 0) begin
            fifo.src_empty = 1'b0;
            fifo.src_data  = src_q[0][31:0];
        end else begin
            fifo.src_empty = 1'b1;
            fifo.src_data  = $urandom();
        end
    end

    always @(negedge clk) begin
        if (hold_left > 0) begin
            fifo.sink_full = 1'b1;
            hold_left--;
        end else if (hold_arm && sink_got.size() == 1) begin
            fifo.sink_full = 1'b1;
            hold_left = 3;
            hold_arm  = 1'b0;
        end else if (fmode == 1) begin
            fifo.sink_full = ($urandom_range(0, 2) == 0);
        end else begin
            fifo.sink_full = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (dp_en) dp_got.push_back(dp_sample);
        if (ref_wren) wr_got.push_back({ref_waddr, ref_wdata});
        if (fifo.src_rden && src_q.size() > 0) void'(src_q.pop_front());
        if (fifo.src_rden && fifo.src_empty) viol++;
        if (prev_full && sink_got.size() > 0 && fifo.sink_data != prev_data) stab_err++;
        if (fifo.sink_wren) begin
            if (fifo.sink_full) viol++;
            sink_got.push_back(fifo.sink_data);
        end
        prev_full = fifo.sink_full;
        prev_data = fifo.sink_data;
    end

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_logs();
        src_q.delete();
        sink_got.delete();
        dp_got.delete();
        wr_got.delete();
        done_cnt  = 0;
        prev_full = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_src_rden"}, fifo.src_rden, 0);
        check({tag, "_sink_wren"}, fifo.sink_wren, 0);
        check({tag, "_sink_data"}, fifo.sink_data, 0);
        check({tag, "_ref_wren"}, ref_wren, 0);
        check({tag, "_ref_waddr"}, ref_waddr, 0);
        check({tag, "_ref_wdata"}, ref_wdata, 0);
        check({tag, "_ref_raddr"}, ref_raddr, 0);
        check({tag, "_dp_rst"}, dp_rst, 1);
        check({tag, "_dp_en"}, dp_en, 0);
        check({tag, "_dp_sample"}, dp_sample, 0);
    endtask

    task automatic recover();
        rst = 1'b1;
        dp_done = 1'b0;
        clear_logs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_cmd(input string tag, input int mode, input logic [31:0] rl,
                           input int sl, input logic [15:0] thr, input logic [31:0] qid,
                           input logic [15:0] mv, input logic [31:0] pos, input int delay,
                           input int gap_pct, input int gap_after, input int fm);
        bit bad, supp, got_done, timed_out, pb, bt;
        int n, budget;
        logic [31:0] exp_sink[$];
        bad  = (mode == 3) || (rl == 0) || (rl > 32'd32768) ||
               (mode != 1 && (sl == 0 || sl > 250));
        supp = !bad && mode == 2 && (mv > thr);
        clear_logs();
        fmode    = fm;
        hold_arm = (fm == 2);
        n = (mode == 1) ? int'(rl) : sl;
        if (!bad) begin
            if (data_q.size() != n) begin
                data_q.delete();
                for (int i = 0; i < n; i++) data_q.push_back($urandom());
            end
            if (mode != 1) src_q.push_back({1'b0, qid});
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 99) < gap_pct) src_q.push_back(33'h1_0000_0000);
                src_q.push_back({1'b0, data_q[i]});
                if (i == gap_after) src_q.push_back(33'h1_0000_0000);
            end
        end
        @(negedge clk);
        start = 1'b1;
        op_mode = mode[1:0];
        ref_len = rl;
        sqg_len = sl[7:0];
        threshold = thr;
        timed_out = 1'b0;
        if (!bad && mode != 1) begin
            budget = 0;
            while (dp_got.size() < sl && budget < 3000) begin
                tick();
                budget++;
            end
            if (budget >= 3000) timed_out = 1'b1;
            repeat (delay) tick();
            dp_minval   = mv;
            dp_position = pos;
            dp_done     = 1'b1;
        end
        got_done = 1'b0;
        pb = busy;
        budget = 0;
        while (budget < 3000) begin
            pb = busy;
            tick();
            budget++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        bt = busy;
        dp_done = 1'b0;
        check({tag, "_sample_timeout"}, timed_out, 0);
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_busy_at_done"}, bt, 0);
        check({tag, "_busy_before_done"}, pb, !bad);
        repeat (3) tick();
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_err"}, err, bad);
        check({tag, "_src_left"}, src_q.size(), 0);
        check({tag, "_wr_count"}, wr_got.size(), (!bad && mode == 1) ? n : 0);
        if (!bad && mode == 1)
            for (int i = 0; i < n && i < wr_got.size(); i++)
                check($sformatf("%s_wr%0d", tag, i), wr_got[i], {i[14:0], data_q[i][15:0]});
        check({tag, "_dp_count"}, dp_got.size(), (!bad && mode != 1) ? n : 0);
        if (!bad && mode != 1)
            for (int i = 0; i < n && i < dp_got.size(); i++)
                check($sformatf("%s_dp%0d", tag, i), dp_got[i], data_q[i][15:0]);
        if (!bad && mode != 1 && !supp) begin
            exp_sink.push_back(qid);
            exp_sink.push_back(pos);
            exp_sink.push_back(32'hA500_0000 | {16'h0, mv});
        end
        check({tag, "_sink_count"}, sink_got.size(), exp_sink.size());
        for (int i = 0; i < exp_sink.size() && i < sink_got.size(); i++)
            check($sformatf("%s_sink%0d", tag, i), sink_got[i], exp_sink[i]);
        if (fm == 2) check({tag, "_hold_applied"}, hold_arm, 0);
        check({tag, "_handshake"}, viol, 0);
        check({tag, "_stable"}, stab_err, 0);
        data_q.delete();
        fmode = 0;
        hold_arm = 1'b0;
        if (!got_done) recover();
    endtask

    initial begin
        int budget;
        fifo.src_empty = 1'b1;
        fifo.src_data  = '0;
        fifo.sink_full = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        @(negedge clk);

        data_q = '{32'd10, 32'd20, 32'd30, 32'd40};
        run_cmd("load4", 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_cmd("query", 0, 100, 3, 0, 32'h1234, 16'h0042, 77, 5, 0, -1, 0);
        run_cmd("tq_supp", 2, 100, 3, 16'h0040, 32'h1234, 16'h0042, 77, 5, 0, -1, 0);
        run_cmd("tq_pass", 2, 100, 3, 16'h0042, 32'h1234, 16'h0042, 77, 5, 0, -1, 0);
        run_cmd("hold", 0, 100, 3, 0, 32'hCAFE_0001, 16'h0123, 32'h0BAD_0099, 2, 0, -1, 2);
        run_cmd("e_op3", 3, 100, 3, 0, 0, 0, 0, 0, 0, -1, 0);
        run_cmd("e_rl0", 0, 0, 3, 0, 0, 0, 0, 0, 0, -1, 0);
        run_cmd("e_sq251", 0, 100, 251, 0, 0, 0, 0, 0, 0, -1, 0);
        run_cmd("e_rlbig", 1, 32769, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        run_cmd("e_clear", 0, 32768, 2, 0, 32'h77, 16'h5, 32'h9, 1, 0, -1, 0);

        clear_logs();
        src_q.push_back({1'b0, 32'h0000_0055});
        src_q.push_back({1'b0, 32'h0000_1111});
        src_q.push_back({1'b0, 32'h0000_2222});
        @(negedge clk);
        start = 1'b1; op_mode = 2'd0; ref_len = 32'd100; sqg_len = 8'd3;
        budget = 0;
        while (dp_got.size() < 2 && budget < 200) begin
            tick();
            budget++;
        end
        check("midrst_samples", dp_got.size(), 2);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        clear_logs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd("after_rst", 0, 100, 3, 0, 32'h1234, 16'h0042, 77, 5, 0, -1, 0);

        for (int k = 0; k < 12; k++) begin
            int mode, sl;
            logic [31:0] rl;
            mode = $urandom_range(0, 4);
            if (mode == 4) mode = 2;
            if (k == 5) mode = 0;
            rl = (mode == 1) ? 32'($urandom_range(1, 24)) : 32'($urandom_range(1, 32768));
            if (k == 5) rl = 32'd32768;
            if (k == 6) rl = 32'd32769;
            sl = $urandom_range(1, 12);
            if (k == 7) sl = 250;
            if (k == 8) sl = 0;
            run_cmd($sformatf("rnd%0d", k), mode, rl, sl, 16'($urandom_range(0, 200)),
                    $urandom(), 16'($urandom_range(0, 200)), $urandom(),
                    $urandom_range(0, 6), $urandom_range(0, 40), -1, $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
